regfile_ctrl: RTL and testbench
===============================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 sampled at a clk rising edge resets).
REQ-003 SHALL have port wb_we  input  1  pipeline writeback request.
REQ-004 SHALL have port wb_rd  input  5  writeback destination register.
REQ-005 SHALL have port wb_data  input  32  writeback data.
REQ-006 SHALL have port dbg_we  input  1  debug write request, held until dbg_ack.
REQ-007 SHALL have port dbg_rd  input  5  debug destination register.
REQ-008 SHALL have port dbg_data  input  32  debug write data.
REQ-009 SHALL have port dump_req  input  1  request a full 32-register dump.
REQ-010 SHALL have port rf_dump_data  input  32  register file read data for rf_dump_addr.
REQ-011 SHALL have port rf_we  output  1  register file write enable.
REQ-012 SHALL have port rf_rd  output  5  register file write address.
REQ-013 SHALL have port rf_data  output  32  register file write data.
REQ-014 SHALL have port rf_dump_addr  output  5  register file dump read address.
REQ-015 SHALL have port dbg_ack  output  1  one-cycle pulse: debug write granted this cycle.
REQ-016 SHALL have port stall  output  1  pipeline must hold; writeback not accepted.
REQ-017 SHALL have port busy  output  1  controller in INIT or DUMP.
REQ-018 SHALL have port dump_valid  output  1  dump_idx/dump_data valid this cycle.
REQ-019 SHALL have port dump_idx  output  5  index of dumped register.
REQ-020 SHALL have port dump_data  output  32  dumped register value.
REQ-021 SHALL have port dump_done  output  1  one-cycle pulse with the last dump_valid (dump_idx=31).

Function
REQ-022 SHALL implement states INIT, RUN, DUMP with a 5-bit index counter idx.
REQ-023 INIT: rf_we=1, rf_rd=idx, rf_data = 0x000001F4 for idx=2, 0x10000000 for idx=3, else 0; idx+1 per cycle; after idx=31 -> RUN, idx=0.
REQ-024 INIT: stall=1, busy=1, dbg_ack=0; wb/dbg requests ignored.
REQ-025 RUN, wb_we=1: rf_we=(wb_rd!=0), rf_rd=wb_rd, rf_data=wb_data, same cycle (combinational); stall=0.
REQ-026 RUN, wb_we=0, dbg_we=1: rf_we=(dbg_rd!=0), rf_rd=dbg_rd, rf_data=dbg_data, dbg_ack=1.
REQ-027 Writeback SHALL have fixed priority over debug; a waiting dbg_we gets no ack until a cycle with wb_we=0.
REQ-028 Writes to x0 SHALL be suppressed (rf_we=0) but still consume the grant (dbg_ack still pulses).
REQ-029 RUN, dump_req=1: the RUN-cycle write (REQ-025/026) still occurs; next state DUMP, idx=0.
REQ-030 dump_req during INIT SHALL be latched in a pending flag; DUMP entered directly after INIT completes instead of RUN.
REQ-031 DUMP: rf_dump_addr=idx, rf_we=0, stall=1, busy=1, dbg_ack=0; idx+1 per cycle; after idx=31 -> RUN.
REQ-032 Dump data SHALL be registered: dump_valid=1, dump_idx=previous idx, dump_data=rf_dump_data sampled, one cycle after each DUMP cycle; the 32nd pulse (with dump_done) lands in the first RUN cycle.
REQ-033 dump_req during DUMP SHALL be ignored (not queued).
REQ-034 rf_dump_addr SHALL be 0 outside DUMP; dump_idx/dump_data hold last value when dump_valid=0.

Reset
REQ-035 rst=0 SHALL force state=INIT, idx=0, pending dump cleared, aborting any INIT or DUMP in progress.
REQ-036 While rst=0: rf_we=0, rf_rd=0, rf_data=0, rf_dump_addr=0, dbg_ack=0, dump_valid=0, dump_done=0, dump_idx=0, dump_data=0, stall=1, busy=1.
REQ-037 First rising edge with rst=1 SHALL perform the idx=0 INIT write; RUN reached 32 cycles after reset release.

Verification
REQ-038 Reset release -> 32 consecutive rf_we cycles, rf_rd 0..31, x2=0x1F4, x3=0x10000000, others 0; stall=1 throughout, 0 in cycle 33.
REQ-039 RUN, wb_we=1 wb_rd=5 and dbg_we=1 dbg_rd=6 same cycle -> cycle 1 writes x5, dbg_ack=0; cycle 2 (wb_we=0) writes x6, dbg_ack=1.
REQ-040 RUN, wb_we=1 wb_rd=0 wb_data=0xDEADBEEF -> rf_we=0, stall=0.
REQ-041 RUN, dump_req with registers preloaded x[i]=i*4 -> 32 dump_valid pulses, dump_idx 0..31, dump_data i*4, dump_done with idx 31; stall=1 for 32 cycles.
REQ-042 dump_req pulsed during INIT -> DUMP starts immediately after idx=31 INIT write, with no RUN cycle between.
REQ-043 rst=0 asserted at dump idx=10 -> next cycle dump_valid=0, INIT restarts from idx=0, no dump_done.

Source files
------------

// File: rtl/regfile_ctrl_if.sv
// Bus bundle between the pipeline/debug side and the register file controller.
// Signal names match the controller's documented port list.
interface regfile_ctrl_if;
  // Pipeline writeback request
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // Debug write request, held until acknowledged
  logic        dbg_we;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  // Dump request and register file read-back data
  logic        dump_req;
  logic [31:0] rf_dump_data;
  // Register file write port and dump read address
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [4:0]  rf_dump_addr;
  // Status
  logic        stall;
  logic        busy;
  // Registered dump stream
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;

  // Requester side: pipeline, debugger and register file read port
  modport master (
    output wb_we, wb_rd, wb_data,
    output dbg_we, dbg_rd, dbg_data,
    output dump_req, rf_dump_data,
    input  dbg_ack, rf_we, rf_rd, rf_data, rf_dump_addr,
    input  stall, busy, dump_valid, dump_idx, dump_data, dump_done
  );

  // Controller side
  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  dbg_we, dbg_rd, dbg_data,
    input  dump_req, rf_dump_data,
    output dbg_ack, rf_we, rf_rd, rf_data, rf_dump_addr,
    output stall, busy, dump_valid, dump_idx, dump_data, dump_done
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Register file write-port controller.
// After reset it walks all 32 registers writing their boot values (INIT), then
// arbitrates the write port between pipeline writeback (higher priority) and a
// debug port (RUN). A dump request streams every register out, one per cycle,
// through a registered output (DUMP).
module regfile_ctrl (
  input logic          clk,
  input logic          rst,
  regfile_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StDump
  } state_e;

  localparam logic [4:0] LastIdx = 5'd31;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  // A dump requested while INIT is running, serviced as soon as INIT ends
  logic        pend_q, pend_d;

  logic        dump_valid_q, dump_valid_d;
  logic        dump_done_q, dump_done_d;
  logic [4:0]  dump_idx_q, dump_idx_d;
  logic [31:0] dump_data_q, dump_data_d;

  // Boot value of each architectural register (x2 = stack, x3 = global ptr)
  function automatic logic [31:0] boot_value(input logic [4:0] i);
    logic [31:0] v;
    unique case (i)
      5'd2:    v = 32'h0000_01F4;
      5'd3:    v = 32'h1000_0000;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // Next-state logic: mode sequencing, index counter and dump capture
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    dump_valid_d = 1'b0;
    dump_done_d  = 1'b0;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;

    unique case (state_q)
      StInit: begin
        idx_d = idx_q + 5'd1;
        if (bus.dump_req) begin
          pend_d = 1'b1;
        end
        if (idx_q == LastIdx) begin
          idx_d   = 5'd0;
          pend_d  = 1'b0;
          // A request on the very last INIT cycle counts as well
          state_d = (pend_q || bus.dump_req) ? StDump : StRun;
        end
      end

      StRun: begin
        if (bus.dump_req) begin
          state_d = StDump;
          idx_d   = 5'd0;
        end
      end

      StDump: begin
        // Read data for this cycle's address is captured and shown next cycle
        dump_valid_d = 1'b1;
        dump_idx_d   = idx_q;
        dump_data_d  = bus.rf_dump_data;
        idx_d        = idx_q + 5'd1;
        if (idx_q == LastIdx) begin
          dump_done_d = 1'b1;
          state_d     = StRun;
          idx_d       = 5'd0;
        end
      end

      default: begin
        state_d = StInit;
        idx_d   = 5'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Output decode: write-port mux, handshake, status and dump stream
  always_comb begin
    bus.rf_we        = 1'b0;
    bus.rf_rd        = 5'd0;
    bus.rf_data      = 32'd0;
    bus.rf_dump_addr = 5'd0;
    bus.dbg_ack      = 1'b0;
    bus.stall        = 1'b1;
    bus.busy         = 1'b1;
    bus.dump_valid   = 1'b0;
    bus.dump_done    = 1'b0;
    bus.dump_idx     = 5'd0;
    bus.dump_data    = 32'd0;

    // Everything is held quiet while reset is low, even before the reset edge
    if (rst) begin
      bus.dump_valid = dump_valid_q;
      bus.dump_done  = dump_done_q;
      bus.dump_idx   = dump_idx_q;
      bus.dump_data  = dump_data_q;

      unique case (state_q)
        StInit: begin
          bus.rf_we   = 1'b1;
          bus.rf_rd   = idx_q;
          bus.rf_data = boot_value(idx_q);
        end

        StRun: begin
          bus.stall = 1'b0;
          bus.busy  = 1'b0;
          if (bus.wb_we) begin
            bus.rf_we   = (bus.wb_rd != 5'd0);
            bus.rf_rd   = bus.wb_rd;
            bus.rf_data = bus.wb_data;
          end else if (bus.dbg_we) begin
            // x0 writes are dropped but the grant is still consumed
            bus.rf_we   = (bus.dbg_rd != 5'd0);
            bus.rf_rd   = bus.dbg_rd;
            bus.rf_data = bus.dbg_data;
            bus.dbg_ack = 1'b1;
          end
        end

        StDump: begin
          bus.rf_dump_addr = idx_q;
        end

        default: begin
          bus.stall = 1'b1;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StInit;
      idx_q        <= 5'd0;
      pend_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_idx_q   <= 5'd0;
      dump_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: directed phases plus randomized RUN
// traffic, checked against a register-level reference model.
module tb_regfile_ctrl;

  logic clk = 1'b0;
  logic rst;

  regfile_ctrl_if bus ();

  regfile_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file attached to the controller's write port
  logic [31:0] mem [32];
  always @(posedge clk) if (bus.rf_we === 1'b1) mem[bus.rf_rd] <= bus.rf_data;
  assign bus.rf_dump_data = mem[bus.rf_dump_addr];

  // Reference model: expected architectural register contents
  logic [31:0] ref_regs [32];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] boot_val(input int i);
    if (i == 2) return 32'h1F4;
    if (i == 3) return 32'h1000_0000;
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic ref_write(input logic [4:0] rd, input logic [31:0] d);
    if (rd != 5'd0) ref_regs[rd] = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, ".rf_rd"}, 32'(bus.rf_rd), 32'd0);
    chk({tag, ".rf_data"}, bus.rf_data, 32'd0);
    chk({tag, ".rf_dump_addr"}, 32'(bus.rf_dump_addr), 32'd0);
    chk({tag, ".dbg_ack"}, 32'(bus.dbg_ack), 32'd0);
    chk({tag, ".dump_valid"}, 32'(bus.dump_valid), 32'd0);
    chk({tag, ".dump_done"}, 32'(bus.dump_done), 32'd0);
    chk({tag, ".dump_idx"}, 32'(bus.dump_idx), 32'd0);
    chk({tag, ".dump_data"}, bus.dump_data, 32'd0);
    chk({tag, ".stall"}, 32'(bus.stall), 32'd1);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
  endtask

  // 32 boot writes; a held debug request and random writebacks must be ignored
  task automatic run_init(input int pulse_at);
    bus.dbg_we   = 1'b1;
    bus.dbg_rd   = 5'($urandom);
    bus.dbg_data = $urandom;
    for (int i = 0; i < 32; i++) begin
      bus.wb_we    = 1'($urandom_range(0, 1));
      bus.wb_rd    = 5'($urandom);
      bus.wb_data  = $urandom;
      bus.dump_req = (i == pulse_at);
      settle();
      chk($sformatf("init%0d.rf_we", i), 32'(bus.rf_we), 32'd1);
      chk($sformatf("init%0d.rf_rd", i), 32'(bus.rf_rd), 32'(i));
      chk($sformatf("init%0d.rf_data", i), bus.rf_data, boot_val(i));
      chk($sformatf("init%0d.stall", i), 32'(bus.stall), 32'd1);
      chk($sformatf("init%0d.busy", i), 32'(bus.busy), 32'd1);
      chk($sformatf("init%0d.dbg_ack", i), 32'(bus.dbg_ack), 32'd0);
      chk($sformatf("init%0d.dump_done", i), 32'(bus.dump_done), 32'd0);
      tick();
    end
    bus.dump_req = 1'b0;
    bus.wb_we    = 1'b0;
    for (int r = 0; r < 32; r++) ref_regs[r] = boot_val(r);
  endtask

  // 32 DUMP cycles then the first RUN cycle carrying the last dump beat.
  // A debug request is held (bus.dbg_we=1) across the whole dump.
  task automatic dump_body(input string tag);
    logic [31:0] last;
    for (int k = 0; k < 32; k++) begin
      bus.wb_we    = 1'($urandom_range(0, 1));
      bus.wb_rd    = 5'($urandom);
      bus.wb_data  = $urandom;
      bus.dump_req = 1'($urandom_range(0, 1));
      settle();
      chk($sformatf("%s%0d.rf_we", tag, k), 32'(bus.rf_we), 32'd0);
      chk($sformatf("%s%0d.stall", tag, k), 32'(bus.stall), 32'd1);
      chk($sformatf("%s%0d.busy", tag, k), 32'(bus.busy), 32'd1);
      chk($sformatf("%s%0d.dbg_ack", tag, k), 32'(bus.dbg_ack), 32'd0);
      chk($sformatf("%s%0d.addr", tag, k), 32'(bus.rf_dump_addr), 32'(k));
      chk($sformatf("%s%0d.valid", tag, k), 32'(bus.dump_valid), 32'(k > 0));
      chk($sformatf("%s%0d.done", tag, k), 32'(bus.dump_done), 32'd0);
      if (k > 0) begin
        chk($sformatf("%s%0d.idx", tag, k), 32'(bus.dump_idx), 32'(k - 1));
        chk($sformatf("%s%0d.data", tag, k), bus.dump_data, ref_regs[k-1]);
      end
      tick();
    end
    bus.wb_we    = 1'b0;
    bus.dump_req = 1'b0;
    last = ref_regs[31];
    settle();
    chk({tag, "_end.valid"}, 32'(bus.dump_valid), 32'd1);
    chk({tag, "_end.idx"}, 32'(bus.dump_idx), 32'd31);
    chk({tag, "_end.data"}, bus.dump_data, last);
    chk({tag, "_end.done"}, 32'(bus.dump_done), 32'd1);
    chk({tag, "_end.stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_end.addr"}, 32'(bus.rf_dump_addr), 32'd0);
    chk({tag, "_end.dbg_ack"}, 32'(bus.dbg_ack), 32'd1);
    chk({tag, "_end.rf_we"}, 32'(bus.rf_we), 32'(bus.dbg_rd != 5'd0));
    ref_write(bus.dbg_rd, bus.dbg_data);
    tick();
    bus.dbg_we = 1'b0;
    settle();
    chk({tag, "_post.valid"}, 32'(bus.dump_valid), 32'd0);
    chk({tag, "_post.done"}, 32'(bus.dump_done), 32'd0);
    chk({tag, "_post.idx_hold"}, 32'(bus.dump_idx), 32'd31);
    chk({tag, "_post.data_hold"}, bus.dump_data, last);
    tick();
  endtask

  // RUN cycle with dump_req (optionally writing too), then the dump itself
  task automatic do_dump(input string tag, input bit wr_first);
    bus.dbg_we   = 1'b0;
    bus.wb_we    = wr_first;
    bus.wb_rd    = 5'($urandom);
    bus.wb_data  = $urandom;
    bus.dump_req = 1'b1;
    settle();
    chk({tag, "_req.stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_req.rf_we"}, 32'(bus.rf_we), 32'(wr_first && bus.wb_rd != 5'd0));
    if (wr_first) ref_write(bus.wb_rd, bus.wb_data);
    tick();
    bus.dbg_we   = 1'b1;
    bus.dbg_rd   = 5'($urandom);
    bus.dbg_data = $urandom;
    dump_body(tag);
  endtask

  initial begin
    bit          dbg_pend;
    bit          exp_we;
    bit          exp_ack;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    rst          = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'hA5A5_A5A5;
    bus.dbg_we   = 1'b1;
    bus.dbg_rd   = 5'd9;
    bus.dbg_data = 32'h1234_5678;
    bus.dump_req = 1'b1;
    repeat (3) tick();
    settle();
    chk_reset("rst_hold");
    tick();

    // Boot sequence, then the first RUN cycle grants the debug request held through INIT
    rst = 1'b1;
    run_init(-1);
    settle();
    chk("run1.stall", 32'(bus.stall), 32'd0);
    chk("run1.busy", 32'(bus.busy), 32'd0);
    chk("run1.dbg_ack", 32'(bus.dbg_ack), 32'd1);
    chk("run1.rf_we", 32'(bus.rf_we), 32'(bus.dbg_rd != 5'd0));
    ref_write(bus.dbg_rd, bus.dbg_data);
    tick();
    bus.dbg_we = 1'b0;

    // Writeback beats a simultaneous debug request
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_0555;
    bus.dbg_we = 1'b1; bus.dbg_rd = 5'd6; bus.dbg_data = 32'h0000_0666;
    settle();
    chk("prio1.rf_we", 32'(bus.rf_we), 32'd1);
    chk("prio1.rf_rd", 32'(bus.rf_rd), 32'd5);
    chk("prio1.rf_data", bus.rf_data, 32'h0000_0555);
    chk("prio1.dbg_ack", 32'(bus.dbg_ack), 32'd0);
    chk("prio1.stall", 32'(bus.stall), 32'd0);
    ref_write(5'd5, 32'h0000_0555);
    tick();
    bus.wb_we = 1'b0;
    settle();
    chk("prio2.rf_we", 32'(bus.rf_we), 32'd1);
    chk("prio2.rf_rd", 32'(bus.rf_rd), 32'd6);
    chk("prio2.rf_data", bus.rf_data, 32'h0000_0666);
    chk("prio2.dbg_ack", 32'(bus.dbg_ack), 32'd1);
    ref_write(5'd6, 32'h0000_0666);
    tick();
    bus.dbg_we = 1'b0;

    // Writeback to x0 is dropped
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD_BEEF;
    settle();
    chk("x0wb.rf_we", 32'(bus.rf_we), 32'd0);
    chk("x0wb.stall", 32'(bus.stall), 32'd0);
    tick();
    bus.wb_we = 1'b0;

    // Randomized RUN traffic against the priority/x0 rules
    dbg_pend = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.wb_we   = ($urandom_range(0, 9) < 5);
      bus.wb_rd   = 5'($urandom);
      bus.wb_data = $urandom;
      if (!dbg_pend && $urandom_range(0, 2) == 0) begin
        dbg_pend     = 1'b1;
        bus.dbg_rd   = 5'($urandom);
        bus.dbg_data = $urandom;
      end
      bus.dbg_we = dbg_pend;
      exp_we = 1'b0; exp_ack = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
      if (bus.wb_we) begin
        exp_we = (bus.wb_rd != 5'd0); exp_rd = bus.wb_rd; exp_data = bus.wb_data;
      end else if (dbg_pend) begin
        exp_we = (bus.dbg_rd != 5'd0); exp_rd = bus.dbg_rd; exp_data = bus.dbg_data;
        exp_ack = 1'b1;
      end
      settle();
      chk($sformatf("rnd%0d.rf_we", n), 32'(bus.rf_we), 32'(exp_we));
      chk($sformatf("rnd%0d.dbg_ack", n), 32'(bus.dbg_ack), 32'(exp_ack));
      chk($sformatf("rnd%0d.stall", n), 32'(bus.stall), 32'd0);
      if (exp_we) begin
        chk($sformatf("rnd%0d.rf_rd", n), 32'(bus.rf_rd), 32'(exp_rd));
        chk($sformatf("rnd%0d.rf_data", n), bus.rf_data, exp_data);
        ref_write(exp_rd, exp_data);
      end
      tick();
      if (exp_ack) dbg_pend = 1'b0;
    end
    bus.wb_we  = 1'b0;
    bus.dbg_we = 1'b0;

    // Dump after random traffic, with a write in the requesting cycle
    do_dump("dumpr", 1'b1);

    // Preload x[i] = i*4 and dump
    for (int i = 1; i < 32; i++) begin
      bus.wb_we = 1'b1; bus.wb_rd = 5'(i); bus.wb_data = 32'(i * 4);
      settle();
      chk($sformatf("pre%0d.rf_we", i), 32'(bus.rf_we), 32'd1);
      ref_write(5'(i), 32'(i * 4));
      tick();
    end
    bus.wb_we = 1'b0;
    do_dump("dumpp", 1'b0);

    // Reset asserted at dump index 10 aborts the dump
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    settle();
    chk_reset("rst_dump");
    tick();
    settle();
    chk_reset("rst_dump2");
    tick();

    // Reboot with a dump request pulsed mid-INIT: DUMP follows INIT directly
    rst = 1'b1;
    run_init(5);
    dump_body("dumpi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
